// File: rtl/multicycle_controller_pkg.sv
// Shared LEGv8 definitions for the multi-cycle controller: opcode patterns,
// ALU and operand-B select codes, FSM state encoding and decoded opcode class.
package legv8_pkg;

  localparam int OPC_W     = 11;
  localparam int B_PFX_W   = 6;
  localparam int CB_PFX_W  = 8;
  localparam int IMM_PFX_W = 10;

  localparam logic [B_PFX_W-1:0]   OPC_B    = 6'b000101;
  localparam logic [CB_PFX_W-1:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [CB_PFX_W-1:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [IMM_PFX_W-1:0] OPC_ADDI = 10'b1001000100;
  localparam logic [IMM_PFX_W-1:0] OPC_SUBI = 10'b1101000100;
  localparam logic [OPC_W-1:0]     OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0]     OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0]     OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0]     OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0]     OPC_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0]     OPC_LDUR = 11'b11111000010;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    MEM_WRITE = 4'd6,
    WB_ALU    = 4'd7,
    WB_MEM    = 4'd8,
    BRANCH    = 4'd9
  } state_e;

  typedef struct packed {
    logic r_type;
    logic i_type;
    logic load;
    logic store;
    logic b;
    logic cbz;
    logic cbnz;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/status inputs and all strobes.
interface multicycle_controller_if;
  logic [10:0] opCode;
  logic        zero;
  logic        memReady;
  logic        pcWrite;
  logic        pcSrc;
  logic        irWrite;
  logic        iOrD;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        regWrite;
  logic        reg2Loc;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [3:0]  aluOp;
  logic        illegalOp;
  logic        memFault;
  logic [3:0]  state;

  modport master (
    input  opCode, zero, memReady,
    output pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, memToReg,
           regWrite, reg2Loc, aluSrcA, aluSrcB, aluOp, illegalOp, memFault, state
  );

  modport slave (
    output opCode, zero, memReady,
    input  pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, memToReg,
           regWrite, reg2Loc, aluSrcA, aluSrcB, aluOp, illegalOp, memFault, state
  );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus the ALU
// operation used by R-type and immediate instructions.
module opcode_decoder
  import legv8_pkg::*;
(
  input  logic [OPC_W-1:0] op_code_i,
  output op_class_t        op_class_o,
  output logic [3:0]       alu_op_o
);

  always_comb begin
    op_class_o = '0;
    alu_op_o   = ALU_ADD;
    if (op_code_i[10:5] == OPC_B) begin
      op_class_o.b = 1'b1;
    end else if (op_code_i[10:3] == OPC_CBZ) begin
      op_class_o.cbz = 1'b1;
    end else if (op_code_i[10:3] == OPC_CBNZ) begin
      op_class_o.cbnz = 1'b1;
    end else if (op_code_i[10:1] == OPC_ADDI) begin
      op_class_o.i_type = 1'b1;
    end else if (op_code_i[10:1] == OPC_SUBI) begin
      op_class_o.i_type = 1'b1;
      alu_op_o          = ALU_SUB;
    end else begin
      case (op_code_i)
        OPC_AND: begin
          op_class_o.r_type = 1'b1;
          alu_op_o          = ALU_AND;
        end
        OPC_ADD:  op_class_o.r_type = 1'b1;
        OPC_ORR: begin
          op_class_o.r_type = 1'b1;
          alu_op_o          = ALU_ORR;
        end
        OPC_SUB: begin
          op_class_o.r_type = 1'b1;
          alu_op_o          = ALU_SUB;
        end
        OPC_STUR: op_class_o.store   = 1'b1;
        OPC_LDUR: op_class_o.load    = 1'b1;
        default:  op_class_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 control FSM sharing one ALU and one memory across phases.
// state     | meaning
// FETCH     | read instruction at PC, PC+4 -> PC on memReady
// DECODE    | branch target into aluOut, dispatch on opcode class
// EXEC_R/I  | register or immediate ALU operation
// MEM_ADDR  | effective address for LDUR/STUR
// MEM_READ  | data read, wait for memReady
// MEM_WRITE | data write, wait for memReady
// WB_ALU/MEM| register write-back from aluOut / MDR
// BRANCH    | conditional or unconditional PC update from aluOut
module multicycle_controller
  import legv8_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  op_class_t       op_class;
  logic [3:0]      dec_alu_op;
  logic            req_state;
  logic            timeout;

  opcode_decoder u_dec (
    .op_code_i  (bus.opCode),
    .op_class_o (op_class),
    .alu_op_o   (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign req_state  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  assign timeout    = req_state && !bus.memReady &&
                      (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1));
  // Any exit from a request state (completion or abort) restarts the count.
  assign wait_cnt_d = (req_state && !bus.memReady && !timeout) ? wait_cnt_q + TO_W'(1) : '0;
  assign bus.state  = reset ? 4'd0 : state_q;

  always_comb begin
    state_d       = state_q;
    bus.pcWrite   = 1'b0;
    bus.pcSrc     = 1'b0;
    bus.irWrite   = 1'b0;
    bus.iOrD      = 1'b0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.memToReg  = 1'b0;
    bus.regWrite  = 1'b0;
    bus.reg2Loc   = 1'b0;
    bus.aluSrcA   = 1'b0;
    bus.aluSrcB   = SRCB_REG;
    bus.aluOp     = ALU_AND;
    bus.illegalOp = 1'b0;
    bus.memFault  = 1'b0;

    case (state_q)
      FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = SRCB_FOUR;
        bus.aluOp   = ALU_ADD;
        if (bus.memReady) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          state_d     = DECODE;
        end else if (timeout) begin
          bus.memFault = 1'b1;
        end
      end
      DECODE: begin
        bus.aluSrcB = SRCB_BR;
        bus.aluOp   = ALU_ADD;
        bus.reg2Loc = op_class.cbz | op_class.cbnz | op_class.store;
        if (op_class.illegal) begin
          bus.illegalOp = 1'b1;
          state_d       = FETCH;
        end else if (op_class.r_type) begin
          state_d = EXEC_R;
        end else if (op_class.i_type) begin
          state_d = EXEC_I;
        end else if (op_class.load || op_class.store) begin
          state_d = MEM_ADDR;
        end else begin
          state_d = BRANCH;
        end
      end
      EXEC_R: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_REG;
        bus.aluOp   = dec_alu_op;
        state_d     = WB_ALU;
      end
      EXEC_I: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        bus.aluOp   = dec_alu_op;
        state_d     = WB_ALU;
      end
      MEM_ADDR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        bus.aluOp   = ALU_ADD;
        state_d     = op_class.load ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        bus.memRead = 1'b1;
        bus.iOrD    = 1'b1;
        if (bus.memReady) begin
          state_d = WB_MEM;
        end else if (timeout) begin
          bus.memFault = 1'b1;
          state_d      = FETCH;
        end
      end
      MEM_WRITE: begin
        bus.iOrD    = 1'b1;
        bus.reg2Loc = 1'b1;
        // The aborting cycle must not commit a write alongside memFault.
        bus.memWrite = !timeout;
        if (bus.memReady) begin
          state_d = FETCH;
        end else if (timeout) begin
          bus.memFault = 1'b1;
          state_d      = FETCH;
        end
      end
      WB_ALU: begin
        bus.regWrite = 1'b1;
        state_d      = FETCH;
      end
      WB_MEM: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.pcSrc = 1'b1;
        if (op_class.b) begin
          bus.pcWrite = 1'b1;
        end else begin
          bus.reg2Loc = 1'b1;
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = SRCB_REG;
          bus.aluOp   = ALU_PASSB;
          bus.pcWrite = op_class.cbz ? bus.zero : !bus.zero;
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      bus.pcWrite   = 1'b0;
      bus.pcSrc     = 1'b0;
      bus.irWrite   = 1'b0;
      bus.iOrD      = 1'b0;
      bus.memRead   = 1'b0;
      bus.memWrite  = 1'b0;
      bus.memToReg  = 1'b0;
      bus.regWrite  = 1'b0;
      bus.reg2Loc   = 1'b0;
      bus.aluSrcA   = 1'b0;
      bus.aluSrcB   = '0;
      bus.aluOp     = '0;
      bus.illegalOp = 1'b0;
      bus.memFault  = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle LEGv8 control FSM; replaces single-cycle decode so one ALU and one unified memory are shared across instruction phases.
- Consumes the 11-bit opcode from the instruction register, the ALU zero flag and a memory ready handshake.
- Drives the datapath strobes and mux selects each cycle.
- Adds a memory-wait timeout and illegal-opcode reporting.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for memReady before abort (≥2).
- TO_W, 5, width of wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opCode  in  11  instruction[31:21] from IR (valid from DECODE onward)
- zero  in  1  ALU zero flag, combinational from current ALU inputs
- memReady  in  1  memory completes current read/write this cycle
- pcWrite  out  1  load PC
- pcSrc  out  1  0=ALU result (PC+4), 1=aluOut register (branch target)
- irWrite  out  1  load IR from memory read data
- iOrD  out  1  memory address: 0=PC, 1=aluOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- memToReg  out  1  register write data: 0=aluOut, 1=MDR
- regWrite  out  1  register file write
- reg2Loc  out  1  read-port-2 select: 0=Rm, 1=Rt
- aluSrcA  out  1  0=PC, 1=reg A
- aluSrcB  out  2  00=reg B, 01=constant 4, 10=sign-extended immediate, 11=branch offset<<2
- aluOp  out  4  0000 and, 0001 orr, 0010 add, 0110 sub, 0111 pass-B
- illegalOp  out  1  one-cycle pulse: undefined opcode
- memFault  out  1  one-cycle pulse: memory timeout
- state  out  4  current state encoding (debug)

Behaviour:
- Reset: sampled on clk; state←FETCH; wait counter←0. While reset is high, all outputs are forced to 0.
- Decode, from the shared package:
  - B: opCode[10:5]=000101
  - CBZ: opCode[10:3]=10110100
  - CBNZ: opCode[10:3]=10110101
  - ADDI: opCode[10:1]=1001000100
  - SUBI: opCode[10:1]=1101000100
  - exact 11-bit matches: AND=10001010000, ADD=10001011000, ORR=10101010000, SUB=11001011000, STUR=11111000000, LDUR=11111000010
  - anything else is illegal.
- Strobes are Moore per state, except strobes marked "on memReady" or "on zero", which are qualified combinationally.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=add. On memReady: irWrite=1, pcWrite=1, pcSrc=0, next DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=add (target into aluOut); reg2Loc=1 for CBZ/CBNZ/STUR.
  - Next: R-type→EXEC_R, ADDI/SUBI→EXEC_I, LDUR/STUR→MEM_ADDR, B/CBZ/CBNZ→BRANCH.
  - Illegal: illegalOp=1, next FETCH.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp per opcode → WB_ALU.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOp add/sub → WB_ALU.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=add → MEM_READ (LDUR) or MEM_WRITE (STUR).
- MEM_READ: memRead=1, iOrD=1; on memReady → WB_MEM.
- MEM_WRITE: memWrite=1, iOrD=1, reg2Loc=1; on memReady → FETCH.
- WB_ALU: regWrite=1, memToReg=0 → FETCH.
- WB_MEM: regWrite=1, memToReg=1 → FETCH.
- BRANCH: pcSrc=1 → FETCH.
  - B: pcWrite=1.
  - CBZ/CBNZ: reg2Loc=1, aluSrcA=1, aluSrcB=00, aluOp=0111; pcWrite=zero (CBZ) / !zero (CBNZ).
- Zero-wait latency (memReady high on first request cycle):
  - R/I-type 4 cycles
  - LDUR 5
  - STUR 4
  - branches 3
  - illegal 2
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in FETCH/MEM_READ/MEM_WRITE without memReady.
  - When counter=MEM_TIMEOUT-1 and memReady=0: memFault=1 that cycle, request strobes stay as for the state, no irWrite/pcWrite/regWrite, next FETCH.
  - FETCH retries the same PC.
- memReady on the timeout cycle wins: normal completion, no memFault.
- memReady outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Reset mid-request: request strobes drop to 0 in the reset cycle; next state FETCH.
- pcWrite/regWrite/memWrite are never asserted in the same cycle as memFault or illegalOp.

Decomposition:
- Shared package `legv8_pkg`:
  - opcode constants and prefix widths
  - aluOp codes
  - aluSrcB codes
  - state enum: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WRITE, WB_ALU, WB_MEM, BRANCH
- One sub-module `opcode_decoder`: combinational, opCode → one-hot class (rType, iType, load, store, b, cbz, cbnz, illegal) plus aluOp for R/I-type. The FSM instantiates it.

Test Plan:
- ADD opCode=10001011000, memReady=1 always → states FETCH,DECODE,EXEC_R,WB_ALU; aluOp=0010 in EXEC_R; regWrite=1 only in cycle 4.
- LDUR 11111000010, memReady delayed 3 cycles in MEM_READ → memRead held high 4 cycles; 8 total cycles; WB_MEM asserts memToReg=1, regWrite=1.
- CBZ 10110100xxx, zero=1 then repeat with zero=0 → pcWrite=1, pcSrc=1 in BRANCH; second run pcWrite=0; 3 cycles each.
- Opcode 00000000000 → illegalOp pulses in cycle 2, returns to FETCH, no regWrite/memWrite.
- MEM_TIMEOUT=16, STUR with memReady stuck 0 → memFault on 16th MEM_WRITE cycle, memWrite never completes, next FETCH; memReady=1 on exactly that cycle → completion, no memFault.
- Assert reset during MEM_READ wait → all outputs 0 that cycle, state=FETCH after; counter 0.
